// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-unit signals: the instruction-memory request/response path and
// the decode-side instruction handshake, plus the redirect input from execute.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: credit-limited PC request stream, in-order response
// buffer toward decode, and redirect handling that discards stale in-flight words.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];

    logic          credit_ok;
    logic          req_fire;
    logic          pop;
    logic          push;
    logic [31:0]   redirect_aligned;
    logic [CW-1:0] rsp_dec;

    // Credits cover both outstanding requests and buffered words, so the buffer can never overflow.
    assign credit_ok        = (inflight + fifo_count) < DEPTH_C;
    assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;
    assign rsp_dec          = CW'(bus.imem_rsp_valid);

    assign bus.imem_req_valid = !rst && !bus.redirect && credit_ok;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = !rst && (fifo_count != '0);
    assign bus.instr          = bus.instr_valid ? fifo_word[rd_ptr] : 32'h0;
    assign bus.instr_pc       = bus.instr_valid ? fifo_pc[rd_ptr]   : 32'h0;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign pop      = bus.instr_valid && bus.instr_ready;
    assign push     = bus.imem_rsp_valid && (discard == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC_ALIGNED;
            rsp_pc     <= RESET_PC_ALIGNED;
            inflight   <= '0;
            discard    <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (bus.redirect) begin
            // inflight already includes words pending discard, so every request
            // still outstanding after this cycle becomes stale.
            fetch_pc   <= redirect_aligned;
            rsp_pc     <= redirect_aligned;
            inflight   <= inflight - rsp_dec;
            discard    <= inflight - rsp_dec;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(req_fire) - rsp_dec;
            if (bus.imem_rsp_valid && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_word[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule
